// File: rtl/ei_cmd_parser_pkg.sv
// Shared constants, error/state enums and response-frame builders for the ei_cmd_parser slice.
package ei_cmd_parser_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] OP_WR        = 8'h01;
  localparam logic [7:0] OP_RD        = 8'h02;
  localparam logic [7:0] ERR_MARK     = 8'hEE;
  // Highest ei_regs_t index (EIR_ERROR in ei_mem_pkg); that register is read-only.
  localparam logic [7:0] EIR_ERROR    = 8'h2B;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_OP   = 3'd1,
    ERR_CHK  = 3'd2,
    ERR_ADDR = 3'd3,
    ERR_RO   = 3'd4,
    ERR_TMO  = 3'd5
  } err_code_t;

  typedef enum logic [2:0] {
    S_SYNC, S_OP, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT, S_TX
  } state_t;

  function automatic logic [31:0] rd_frame(logic [7:0] sync, logic [7:0] addr, logic [7:0] data);
    return {sync, addr, data, addr ^ data};
  endfunction

  function automatic logic [31:0] err_frame(logic [7:0] sync, err_code_t code);
    logic [7:0] c;
    c = {5'b0, code};
    return {sync, ERR_MARK, c, ERR_MARK ^ c};
  endfunction

endpackage

// File: rtl/ei_cmd_parser_if.sv
// Bundle of UART byte streams, register-bank strobes and error status around ei_cmd_parser.
interface ei_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       err_pulse;
  logic [2:0] err_code;
  ei_cmd_parser_pkg::state_t dbg_state;

  // rx_valid is a 1-cycle strobe with no back-pressure; tx is valid/ready: tx_data/tx_valid
  // stay stable while tx_valid && !tx_ready, and a byte moves on the edge where both are high.
  modport master (
    input  rx_data, rx_valid, tx_ready, reg_rdata,
    output tx_data, tx_valid, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
           err_pulse, err_code, dbg_state
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_rdata,
    input  tx_data, tx_valid, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
           err_pulse, err_code, dbg_state
  );
endinterface

// File: rtl/ei_cmd_parser_tx_ser.sv
// Four-byte load-and-shift serializer driving the UART TX valid/ready handshake.
module ei_cmd_tx_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] frame,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy
);

  logic [23:0] rest;
  logic [1:0]  left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rest     <= 24'h0;
      left     <= 2'd0;
    end else if (load) begin
      tx_data  <= frame[31:24];
      rest     <= frame[23:0];
      left     <= 2'd3;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (left != 2'd0) begin
        tx_data <= rest[23:16];
        rest    <= {rest[15:0], 8'h00};
        left    <= left - 2'd1;
      end else begin
        tx_valid <= 1'b0;
      end
    end
  end

  assign busy = tx_valid;

endmodule

// File: rtl/ei_cmd_parser.sv
// Framed UART command parser feeding the ei_regs_t register bank.
// Optional inter-byte timeout enabled by defining EI_CMD_TIMEOUT_EN.
module ei_cmd_parser
  import ei_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000
) (
  input logic               clk,
  input logic               rst_n,
  ei_cmd_parser_if.master   bus
);

  state_t      state;
  logic        op_wr;
  logic [7:0]  addr_b;
  logic [7:0]  data_b;
  logic [7:0]  chk_acc;
  logic        ser_load;
  logic [31:0] ser_frame;
  logic        ser_busy;
  err_code_t   new_err;

`ifdef EI_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        in_frame;
  logic        tmo_hit;

  assign in_frame = (state == S_OP) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign tmo_hit  = in_frame && !bus.rx_valid && (tmo_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tmo_cnt <= 32'd0;
    else if (!in_frame || bus.rx_valid || tmo_hit) tmo_cnt <= 32'd0;
    else                                       tmo_cnt <= tmo_cnt + 32'd1;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^32'(TIMEOUT_CYC);
`endif

  // Error precedence at the CHK byte: checksum, then address range, then read-only target.
  always_comb begin
    new_err = ERR_NONE;
    if (bus.rx_valid && state == S_OP && bus.rx_data != OP_WR && bus.rx_data != OP_RD) begin
      new_err = ERR_OP;
    end else if (bus.rx_valid && state == S_CHK) begin
      if (bus.rx_data != chk_acc)              new_err = ERR_CHK;
      else if (addr_b > EIR_ERROR)             new_err = ERR_ADDR;
      else if (op_wr && addr_b == EIR_ERROR)   new_err = ERR_RO;
    end
`ifdef EI_CMD_TIMEOUT_EN
    if (tmo_hit) new_err = ERR_TMO;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_SYNC;
      op_wr         <= 1'b0;
      addr_b        <= 8'h00;
      data_b        <= 8'h00;
      chk_acc       <= 8'h00;
      ser_load      <= 1'b0;
      ser_frame     <= 32'h0;
      bus.reg_addr  <= 6'h00;
      bus.reg_wdata <= 8'h00;
      bus.reg_wr_en <= 1'b0;
      bus.reg_rd_en <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_code  <= ERR_NONE;
    end else begin
      bus.reg_wr_en <= 1'b0;
      bus.reg_rd_en <= 1'b0;
      bus.err_pulse <= 1'b0;
      ser_load      <= 1'b0;
      case (state)
        S_SYNC: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          chk_acc <= 8'h00;
          state   <= S_OP;
        end
        S_OP: if (bus.rx_valid && new_err == ERR_NONE) begin
          op_wr   <= (bus.rx_data == OP_WR);
          chk_acc <= chk_acc ^ bus.rx_data;
          state   <= S_ADDR;
        end
        S_ADDR: if (bus.rx_valid) begin
          addr_b  <= bus.rx_data;
          chk_acc <= chk_acc ^ bus.rx_data;
          state   <= op_wr ? S_DATA : S_CHK;
        end
        S_DATA: if (bus.rx_valid) begin
          data_b  <= bus.rx_data;
          chk_acc <= chk_acc ^ bus.rx_data;
          state   <= S_CHK;
        end
        S_CHK: if (bus.rx_valid && new_err == ERR_NONE) begin
          bus.reg_addr <= addr_b[5:0];
          if (op_wr) begin
            bus.reg_wdata <= data_b;
            bus.reg_wr_en <= 1'b1;
          end else begin
            bus.reg_rd_en <= 1'b1;
          end
          state <= S_EXEC;
        end
        S_EXEC: state <= op_wr ? S_SYNC : S_RDWAIT;
        S_RDWAIT: begin
          ser_frame <= rd_frame(SYNC_BYTE, addr_b, bus.reg_rdata);
          ser_load  <= 1'b1;
          state     <= S_TX;
        end
        S_TX: if (!ser_load && !ser_busy) state <= S_SYNC;
        default: state <= S_SYNC;
      endcase

      if (new_err != ERR_NONE) begin
        bus.err_pulse <= 1'b1;
        bus.err_code  <= new_err;
        ser_frame     <= err_frame(SYNC_BYTE, new_err);
        ser_load      <= 1'b1;
        state         <= S_TX;
      end
    end
  end

  assign bus.dbg_state = state;

  ei_cmd_tx_ser u_tx_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .frame    (ser_frame),
    .tx_ready (bus.tx_ready),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .busy     (ser_busy)
  );

endmodule

// File: tb/tb_ei_cmd_parser.sv
// Bench for ei_cmd_parser: directed frames plus random frames against a protocol-level model.
`timescale 1ns/1ps
module tb_ei_cmd_parser;
  import ei_cmd_parser_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ei_cmd_parser_if bus();

  ei_cmd_parser #(.TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_wr_q[$], obs_wr_q[$];
  logic [15:0] exp_rd_q[$], obs_rd_q[$];
  logic [15:0] exp_err_q[$], obs_err_q[$];
  logic [15:0] exp_tx_q[$], obs_tx_q[$];

  logic [7:0] mem [64];
  logic       rdy_hold_low = 1'b0;
  logic       rdy_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register bank stub: data valid only in the cycle after a read strobe, junk otherwise.
  logic       rb_rd;
  logic [5:0] rb_a;
  always @(posedge clk) begin
    rb_rd = bus.reg_rd_en;
    rb_a  = bus.reg_addr;
    #1 bus.reg_rdata = rb_rd ? mem[rb_a] : 8'($urandom);
  end

  always @(posedge clk) begin
    #1 bus.tx_ready = rdy_hold_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: collect observed events and enforce tx stability while stalled.
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
        check("tx_hold_data", 32'(bus.tx_data), 32'(data_prev));
      end
      if (bus.reg_wr_en) obs_wr_q.push_back({2'b0, bus.reg_addr, bus.reg_wdata});
      if (bus.reg_rd_en) obs_rd_q.push_back({10'b0, bus.reg_addr});
      if (bus.err_pulse) obs_err_q.push_back({13'b0, bus.err_code});
      if (bus.tx_valid && bus.tx_ready) obs_tx_q.push_back({8'b0, bus.tx_data});
      stall_prev = bus.tx_valid && !bus.tx_ready;
      data_prev  = bus.tx_data;
    end
  end

  task automatic send_frame(input logic [7:0] f[$], input int gap_max);
    foreach (f[i]) begin
      int gap;
      gap = $urandom_range(0, gap_max);
      @(posedge clk); #1;
      bus.rx_data  = f[i];
      bus.rx_valid = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] b0, b1, b2, b3);
    exp_tx_q.push_back({8'b0, b0});
    exp_tx_q.push_back({8'b0, b1});
    exp_tx_q.push_back({8'b0, b2});
    exp_tx_q.push_back({8'b0, b3});
  endtask

  task automatic cmp_q(input string tag, input logic [15:0] obs[$], input logic [15:0] exp[$]);
    check({tag, "_count"}, 32'(obs.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(obs[i]), 32'(exp[i]));
  endtask

  task automatic finish_txn(input string tag);
    int cyc;
    cyc = 0;
    while (obs_tx_q.size() < exp_tx_q.size() && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_tx_done_in_time"}, 32'(cyc < 400), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp_q({tag, "_wr"}, obs_wr_q, exp_wr_q);
    cmp_q({tag, "_rd"}, obs_rd_q, exp_rd_q);
    cmp_q({tag, "_err"}, obs_err_q, exp_err_q);
    cmp_q({tag, "_tx"}, obs_tx_q, exp_tx_q);
    obs_wr_q.delete(); exp_wr_q.delete();
    obs_rd_q.delete(); exp_rd_q.delete();
    obs_err_q.delete(); exp_err_q.delete();
    obs_tx_q.delete(); exp_tx_q.delete();
  endtask

  // Protocol-level model of one complete frame (leading SYNC at index 0).
  task automatic model_frame(input logic [7:0] f[$]);
    int op, addr, data, chk, code;
    op = f[1];
    code = 0;
    if (op != 1 && op != 2) begin
      code = 1;
    end else begin
      addr = f[2];
      data = (op == 1) ? int'(f[3]) : 0;
      chk  = (op == 1) ? int'(f[4]) : int'(f[3]);
      if (chk != (op ^ addr ^ data))   code = 2;
      else if (addr > 43)              code = 3;
      else if (op == 1 && addr == 43)  code = 4;
      if (code == 0) begin
        if (op == 1) exp_wr_q.push_back(16'(addr * 256 + data));
        else begin
          exp_rd_q.push_back(16'(addr));
          expect_tx(8'hA5, 8'(addr), mem[addr], 8'(addr) ^ mem[addr]);
        end
      end
    end
    if (code != 0) begin
      exp_err_q.push_back(16'(code));
      expect_tx(8'hA5, 8'hEE, 8'(code), 8'hEE ^ 8'(code));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
    check({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
    check({tag, "_reg_wr_en"}, 32'(bus.reg_wr_en), 32'd0);
    check({tag, "_reg_rd_en"}, 32'(bus.reg_rd_en), 32'd0);
    check({tag, "_err_pulse"}, 32'(bus.err_pulse), 32'd0);
    check({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
    check({tag, "_state"}, 32'(bus.dbg_state), 32'(S_SYNC));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] op, addr, data, chk;
    int pick;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[10] = 8'h77;
    mem[0]  = 8'h3E;

    #3;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write: A5,01,05,3C,38
    exp_wr_q.push_back(16'h053C);
    send_frame('{8'hA5, 8'h01, 8'h05, 8'h3C, 8'h38}, 2);
    finish_txn("wr");
    check("wr_reg_addr_hold", 32'(bus.reg_addr), 32'h05);
    check("wr_reg_wdata_hold", 32'(bus.reg_wdata), 32'h3C);

    // Read: A5,02,0A,08 with reg 0A = 77
    exp_rd_q.push_back(16'h000A);
    expect_tx(8'hA5, 8'h0A, 8'h77, 8'h7D);
    send_frame('{8'hA5, 8'h02, 8'h0A, 8'h08}, 0);
    finish_txn("rd");

    // Read with TX stalled; a write frame sent during the stall must be dropped
    rdy_hold_low = 1'b1;
    exp_rd_q.push_back(16'h000A);
    expect_tx(8'hA5, 8'h0A, 8'h77, 8'h7D);
    send_frame('{8'hA5, 8'h02, 8'h0A, 8'h08}, 1);
    send_frame('{8'hA5, 8'h01, 8'h06, 8'h11, 8'h16}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
      check("stall_tx_data", 32'(bus.tx_data), 32'hA5);
    end
    rdy_hold_low = 1'b0;
    finish_txn("rd_stall");

    // Bad checksum
    exp_err_q.push_back(16'd2);
    expect_tx(8'hA5, 8'hEE, 8'h02, 8'hEC);
    send_frame('{8'hA5, 8'h01, 8'h05, 8'h3C, 8'h00}, 1);
    finish_txn("bad_chk");
    check("err_code_sticky", 32'(bus.err_code), 32'd2);

    // Address out of range, write to read-only, illegal opcode, CHK over ADDR precedence
    exp_err_q.push_back(16'd3);
    expect_tx(8'hA5, 8'hEE, 8'h03, 8'hED);
    send_frame('{8'hA5, 8'h02, 8'h2C, 8'h2E}, 1);
    finish_txn("err_addr");
    exp_err_q.push_back(16'd4);
    expect_tx(8'hA5, 8'hEE, 8'h04, 8'hEA);
    send_frame('{8'hA5, 8'h01, 8'h2B, 8'h55, 8'h7F}, 1);
    finish_txn("err_ro");
    exp_err_q.push_back(16'd1);
    expect_tx(8'hA5, 8'hEE, 8'h01, 8'hEF);
    send_frame('{8'hA5, 8'h07}, 1);
    finish_txn("err_op");
    exp_err_q.push_back(16'd2);
    expect_tx(8'hA5, 8'hEE, 8'h02, 8'hEC);
    send_frame('{8'hA5, 8'h02, 8'h2C, 8'h00}, 1);
    finish_txn("err_prec");

    // Garbage before SYNC
    exp_rd_q.push_back(16'h0000);
    expect_tx(8'hA5, 8'h00, 8'h3E, 8'h3E);
    send_frame('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h02}, 1);
    finish_txn("noise");

    // Reset after the ADDR byte, then a clean frame
    send_frame('{8'hA5, 8'h01, 8'h05}, 0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_wr_q.push_back(16'h0799);
    send_frame('{8'hA5, 8'h01, 8'h07, 8'h99, 8'h9F}, 1);
    finish_txn("post_reset");

`ifdef EI_CMD_TIMEOUT_EN
    exp_err_q.push_back(16'd5);
    expect_tx(8'hA5, 8'hEE, 8'h05, 8'hEB);
    send_frame('{8'hA5, 8'h02}, 0);
    repeat (40) @(posedge clk);
    finish_txn("timeout");
`else
    send_frame('{8'hA5, 8'h02}, 0);
    repeat (40) @(posedge clk);
    exp_rd_q.push_back(16'h000A);
    expect_tx(8'hA5, 8'h0A, 8'h77, 8'h7D);
    send_frame('{8'h0A, 8'h08}, 0);
    finish_txn("no_timeout");
`endif

    // Random frames with random tx_ready
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      f.delete();
      pick = $urandom_range(0, 9);
      op   = (pick < 5) ? 8'h01 : (pick < 9) ? 8'h02 : 8'($urandom_range(3, 255));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(40, 50)) : 8'($urandom_range(0, 43));
      data = 8'($urandom);
      chk  = op ^ addr ^ ((op == 8'h01) ? data : 8'h00);
      if ($urandom_range(0, 7) == 0) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      for (int k = $urandom_range(0, 2); k > 0; k--) f.push_back(8'($urandom_range(0, 8'hA4)));
      f.push_back(8'hA5);
      f.push_back(op);
      if (op == 8'h01 || op == 8'h02) begin
        f.push_back(addr);
        if (op == 8'h01) f.push_back(data);
        f.push_back(chk);
      end
      while (f[0] != 8'hA5) f.pop_front();
      model_frame(f);
      send_frame(f, 2);
      finish_txn($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
